// File: rtl/can_errframe.sv
// rtl/can_errframe.sv - CAN error-frame sequencer and error-event encoder
module can_errframe #(
  parameter int FLAG_LEN  = 6,
  parameter int DELIM_LEN = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clock,
  input  logic       rx,
  input  logic       tx_active,
  input  logic       err_req,
  input  logic [2:0] err_kind,
  input  logic       error_state,
  input  logic       busoff,
  output logic       tx_bit,
  output logic       ef_busy,
  output logic       err,
  output logic [2:0] ko_error,
  output logic       ebf
);

  typedef enum logic [2:0] {S_IDLE, S_FLAG, S_SUPER, S_DELIM, S_BUSOFF} state_t;

  localparam logic [3:0] FLAG_LAST = 4'(FLAG_LEN - 1);
  localparam logic [3:0] FLAG_RUN  = 4'(FLAG_LEN);
  localparam logic [3:0] DELIM_END = 4'(DELIM_LEN - 2);

  state_t     state_q, state_d;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic [3:0] domcnt_q, domcnt_d;
  logic       flag_act_q, flag_act_d;
  logic       tx_lat_q, tx_lat_d;
  logic       prev_rx_q, prev_rx_d;
  logic       tx_bit_q, tx_bit_d;
  logic       ef_busy_q, ef_busy_d;
  logic       err_q, err_d;
  logic [2:0] ko_q, ko_d;
  logic       ebf_q, ebf_d;
  logic [3:0] run;
  logic       entry;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic [2:0] encode(input logic txa, input logic [2:0] kind);
    if (!txa) return 3'b001;
    return (kind == 3'b101) ? 3'b011 : 3'b100;
  endfunction

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    domcnt_d   = domcnt_q;
    flag_act_d = flag_act_q;
    tx_lat_d   = tx_lat_q;
    prev_rx_d  = prev_rx_q;
    tx_bit_d   = tx_bit_q;
    ef_busy_d  = ef_busy_q;
    err_d      = err_q;
    ko_d       = ko_q;
    ebf_d      = ebf_q;
    run        = 4'd0;
    entry      = 1'b0;
    if (clock) begin
      ko_d  = 3'b000;
      ebf_d = 1'b0;
      if (busoff && state_q != S_BUSOFF) begin
        state_d = S_BUSOFF;
        entry   = 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (err_req) begin
              state_d    = S_FLAG;
              entry      = 1'b1;
              tx_lat_d   = tx_active;
              flag_act_d = error_state;
              ko_d       = encode(tx_active, err_kind);
            end
          end
          S_FLAG: begin
            if (flag_act_q) begin
              if (bitcnt_q == FLAG_LAST) begin
                state_d = S_SUPER;
                entry   = 1'b1;
              end else begin
                bitcnt_d = sat_inc(bitcnt_q);
              end
            end else begin
              // Passive flag: length of the current run of identical rx samples
              run       = (bitcnt_q != 4'd0 && rx == prev_rx_q) ? sat_inc(bitcnt_q) : 4'd1;
              prev_rx_d = rx;
              if (run == FLAG_RUN) begin
                state_d = S_SUPER;
                entry   = 1'b1;
              end else begin
                bitcnt_d = run;
              end
            end
          end
          S_SUPER: begin
            if (rx) begin
              state_d = S_DELIM;
              entry   = 1'b1;
            end else begin
              domcnt_d = sat_inc(domcnt_q);
              if (domcnt_q == 4'd0 && !tx_lat_q) ko_d = 3'b010;
              // domcnt saturates, so bitcnt paces the repeats every 8 bits after 14
              if (domcnt_q == 4'd13) begin
                ko_d     = tx_lat_q ? 3'b100 : 3'b010;
                bitcnt_d = 4'd0;
              end else if (domcnt_q >= 4'd14) begin
                if (bitcnt_q == 4'd7) begin
                  ko_d     = tx_lat_q ? 3'b100 : 3'b010;
                  bitcnt_d = 4'd0;
                end else begin
                  bitcnt_d = sat_inc(bitcnt_q);
                end
              end
            end
          end
          S_DELIM: begin
            if (!rx) begin
              state_d    = S_FLAG;
              entry      = 1'b1;
              tx_lat_d   = tx_active;
              flag_act_d = error_state;
              ko_d       = encode(tx_active, 3'b011);
            end else if (bitcnt_q == DELIM_END) begin
              state_d = S_IDLE;
              entry   = 1'b1;
            end else begin
              bitcnt_d = sat_inc(bitcnt_q);
            end
          end
          S_BUSOFF: begin
            if (!busoff) begin
              state_d = S_IDLE;
              entry   = 1'b1;
            end else if (rx) begin
              if (bitcnt_q == 4'd10) begin
                ebf_d    = 1'b1;
                bitcnt_d = 4'd0;
              end else begin
                bitcnt_d = sat_inc(bitcnt_q);
              end
            end else begin
              bitcnt_d = 4'd0;
            end
          end
          default: begin
            state_d = S_IDLE;
            entry   = 1'b1;
          end
        endcase
      end
      if (entry) begin
        bitcnt_d = 4'd0;
        domcnt_d = 4'd0;
      end
      err_d     = (ko_d != 3'b000);
      tx_bit_d  = (state_d == S_FLAG) ? ~flag_act_d : 1'b1;
      ef_busy_d = (state_d != S_IDLE);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      bitcnt_q   <= 4'd0;
      domcnt_q   <= 4'd0;
      flag_act_q <= 1'b0;
      tx_lat_q   <= 1'b0;
      prev_rx_q  <= 1'b1;
      tx_bit_q   <= 1'b1;
      ef_busy_q  <= 1'b0;
      err_q      <= 1'b0;
      ko_q       <= 3'b000;
      ebf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      domcnt_q   <= domcnt_d;
      flag_act_q <= flag_act_d;
      tx_lat_q   <= tx_lat_d;
      prev_rx_q  <= prev_rx_d;
      tx_bit_q   <= tx_bit_d;
      ef_busy_q  <= ef_busy_d;
      err_q      <= err_d;
      ko_q       <= ko_d;
      ebf_q      <= ebf_d;
    end
  end

  assign tx_bit   = tx_bit_q;
  assign ef_busy  = ef_busy_q;
  assign err      = err_q;
  assign ko_error = ko_q;
  assign ebf      = ebf_q;

endmodule
